bcd_mod_counter: RTL and testbench

Parametrised N-digit BCD up/down counter with programmable modulus, synchronous clear, parallel load with validation, and selectable wrap or saturate mode. It is the generic time-of-day and timer digit engine for the seven-segment display designs. Instances chain through registered carry and borrow pulses, for example seconds (mod 60) to minutes (mod 60) to hours (mod 24).

---
 rtl/bcd_mod_counter.sv | 125 ++++++++++++
 tb/tb_bcd_mod_counter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_mod_counter.sv
// N-digit BCD up/down counter with programmable modulus, clear, validated load,
// and wrap/saturate behaviour at the range ends; chains through co/bo pulses.
module bcd_mod_counter #(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned MODULUS = 24,
  parameter int unsigned WRAP    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic                  inc,
  input  logic                  dec,
  output logic [4*DIGITS-1:0]   count,
  output logic                  co,
  output logic                  bo,
  output logic                  load_err,
  output logic                  at_max,
  output logic                  at_min
);

  if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
    $error("bcd_mod_counter: DIGITS must be in 1..4");
  end
  if (MODULUS < 2 || MODULUS > 10**DIGITS) begin : g_bad_modulus
    $error("bcd_mod_counter: MODULUS must be in 2..10**DIGITS");
  end

  function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned         rem;
    r   = '0;
    rem = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  localparam logic [4*DIGITS-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  logic [4*DIGITS-1:0] cnt_inc;
  logic [4*DIGITS-1:0] cnt_dec;
  logic                load_ok;

  // Ripple increment: trailing 9s roll to 0 until the first digit that can absorb the carry.
  always_comb begin
    logic carry;
    cnt_inc = count;
    carry   = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          cnt_inc[4*i +: 4] = '0;
        end else begin
          cnt_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_comb begin
    logic borrow;
    cnt_dec = count;
    borrow  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          cnt_dec[4*i +: 4] = 4'd9;
        end else begin
          cnt_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // With every digit a legal BCD digit, BCD magnitude order equals numeric order.
  always_comb begin
    load_ok = (load_data <= MAX_BCD);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (load_data[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  assign at_max = (count == MAX_BCD);
  assign at_min = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      co       <= 1'b0;
      bo       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      co       <= 1'b0;
      bo       <= 1'b0;
      load_err <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (load) begin
        if (load_ok) count    <= load_data;
        else         load_err <= 1'b1;
      end else if (inc && !dec) begin
        if (!at_max) begin
          count <= cnt_inc;
        end else if (WRAP != 0) begin
          count <= '0;
          co    <= 1'b1;
        end
      end else if (dec && !inc) begin
        if (!at_min) begin
          count <= cnt_dec;
        end else if (WRAP != 0) begin
          count <= MAX_BCD;
          bo    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: directed scenarios plus random traffic on several
// configurations (including a chained pair) against an integer reference model.
module tb_bcd_mod_counter;

  logic clk;
  logic rst_n;

  logic       a_clr, a_load, a_inc, a_dec, a_co, a_bo, a_le, a_max, a_min;
  logic [7:0] a_ld, a_cnt;
  logic       b_clr, b_load, b_inc, b_dec, b_co, b_bo, b_le, b_max, b_min;
  logic [7:0] b_ld, b_cnt;
  logic        c_clr, c_load, c_inc, c_dec, c_co, c_bo, c_le, c_max, c_min;
  logic [11:0] c_ld, c_cnt;
  logic       d_clr, d_load, d_inc, d_dec, d_co, d_bo, d_le, d_max, d_min;
  logic [7:0] d_ld, d_cnt;
  logic       e_clr, e_load, e_co, e_bo, e_le, e_max, e_min;
  logic [7:0] e_ld, e_cnt;

  int compared   = 0;
  int mismatched = 0;

  // Reference state per instance: 0=a(mod24 wrap) 1=b(mod60 sat) 2=c(mod1000 wrap) 3=d(mod60 wrap) 4=e(mod24, fed by d)
  int m_cnt[5];
  bit m_co[5], m_bo[5], m_le[5];

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24), .WRAP(1)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .load(a_load), .load_data(a_ld),
    .inc(a_inc), .dec(a_dec), .count(a_cnt), .co(a_co), .bo(a_bo),
    .load_err(a_le), .at_max(a_max), .at_min(a_min));

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60), .WRAP(0)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .load(b_load), .load_data(b_ld),
    .inc(b_inc), .dec(b_dec), .count(b_cnt), .co(b_co), .bo(b_bo),
    .load_err(b_le), .at_max(b_max), .at_min(b_min));

  bcd_mod_counter #(.DIGITS(3), .MODULUS(1000), .WRAP(1)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .load(c_load), .load_data(c_ld),
    .inc(c_inc), .dec(c_dec), .count(c_cnt), .co(c_co), .bo(c_bo),
    .load_err(c_le), .at_max(c_max), .at_min(c_min));

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60), .WRAP(1)) u_d (
    .clk(clk), .rst_n(rst_n), .clr(d_clr), .load(d_load), .load_data(d_ld),
    .inc(d_inc), .dec(d_dec), .count(d_cnt), .co(d_co), .bo(d_bo),
    .load_err(d_le), .at_max(d_max), .at_min(d_min));

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24), .WRAP(1)) u_e (
    .clk(clk), .rst_n(rst_n), .clr(e_clr), .load(e_load), .load_data(e_ld),
    .inc(d_co), .dec(d_bo), .count(e_cnt), .co(e_co), .bo(e_bo),
    .load_err(e_le), .at_max(e_max), .at_min(e_min));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_ld(input int hi);
    logic [31:0] r;
    if ($urandom_range(0, 1) == 1) r = to_bcd(int'($urandom_range(0, hi)));
    else                           r = 32'($urandom);
    return r[15:0];
  endfunction

  task automatic model_step(input int modv, input bit wrap, input int digits,
                            input bit clr, input bit ld, input logic [15:0] ldv,
                            input bit inc, input bit dec,
                            inout int cnt, output bit co, output bit bo, output bit le);
    int val;
    int dg;
    bit ok;
    co = 1'b0; bo = 1'b0; le = 1'b0;
    if (clr) begin
      cnt = 0;
    end else if (ld) begin
      ok  = 1'b1;
      val = 0;
      for (int i = digits - 1; i >= 0; i--) begin
        dg = int'((ldv >> (4*i)) & 16'hF);
        if (dg > 9) ok = 1'b0;
        val = val * 10 + dg;
      end
      if (ok && val < modv) cnt = val;
      else                  le  = 1'b1;
    end else if (inc && !dec) begin
      if (cnt == modv - 1) begin
        if (wrap) begin cnt = 0; co = 1'b1; end
      end else cnt = cnt + 1;
    end else if (dec && !inc) begin
      if (cnt == 0) begin
        if (wrap) begin cnt = modv - 1; bo = 1'b1; end
      end else cnt = cnt - 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input string nm, input logic [31:0] cnt, input logic co,
                            input logic bo, input logic le, input logic amax,
                            input logic amin, input int k, input int modv);
    chk({nm, ".count"},    cnt,         to_bcd(m_cnt[k]));
    chk({nm, ".co"},       32'(co),     32'(m_co[k]));
    chk({nm, ".bo"},       32'(bo),     32'(m_bo[k]));
    chk({nm, ".load_err"}, 32'(le),     32'(m_le[k]));
    chk({nm, ".at_max"},   32'(amax),   32'(m_cnt[k] == modv - 1));
    chk({nm, ".at_min"},   32'(amin),   32'(m_cnt[k] == 0));
  endtask

  task automatic check_all();
    check_inst("a", 32'(a_cnt), a_co, a_bo, a_le, a_max, a_min, 0, 24);
    check_inst("b", 32'(b_cnt), b_co, b_bo, b_le, b_max, b_min, 1, 60);
    check_inst("c", 32'(c_cnt), c_co, c_bo, c_le, c_max, c_min, 2, 1000);
    check_inst("d", 32'(d_cnt), d_co, d_bo, d_le, d_max, d_min, 3, 60);
    check_inst("e", 32'(e_cnt), e_co, e_bo, e_le, e_max, e_min, 4, 24);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 5; k++) begin
      m_cnt[k] = 0; m_co[k] = 1'b0; m_bo[k] = 1'b0; m_le[k] = 1'b0;
    end
  endtask

  // Upper stage is modelled first so it sees the lower stage's pulses from before this edge.
  task automatic tick();
    model_step(24, 1'b1, 2, e_clr, e_load, 16'(e_ld), m_co[3], m_bo[3],
               m_cnt[4], m_co[4], m_bo[4], m_le[4]);
    model_step(24, 1'b1, 2, a_clr, a_load, 16'(a_ld), a_inc, a_dec,
               m_cnt[0], m_co[0], m_bo[0], m_le[0]);
    model_step(60, 1'b0, 2, b_clr, b_load, 16'(b_ld), b_inc, b_dec,
               m_cnt[1], m_co[1], m_bo[1], m_le[1]);
    model_step(1000, 1'b1, 3, c_clr, c_load, 16'(c_ld), c_inc, c_dec,
               m_cnt[2], m_co[2], m_bo[2], m_le[2]);
    model_step(60, 1'b1, 2, d_clr, d_load, 16'(d_ld), d_inc, d_dec,
               m_cnt[3], m_co[3], m_bo[3], m_le[3]);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    a_clr = 0; a_load = 0; a_inc = 0; a_dec = 0; a_ld = '0;
    b_clr = 0; b_load = 0; b_inc = 0; b_dec = 0; b_ld = '0;
    c_clr = 0; c_load = 0; c_inc = 0; c_dec = 0; c_ld = '0;
    d_clr = 0; d_load = 0; d_inc = 0; d_dec = 0; d_ld = '0;
    e_clr = 0; e_load = 0; e_ld = '0;
  endtask

  initial begin
    logic [15:0] ld16;
    idle_inputs();
    clear_model();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2 check_all();
    #6 rst_n = 1'b1;

    // mod 24 wrap: full cycle of increments
    a_inc = 1;
    for (int i = 0; i < 24; i++) tick();
    a_inc = 0;
    chk("a_wrap_count", 32'(a_cnt), 32'h00);
    chk("a_wrap_co", 32'(a_co), 32'd1);

    a_dec = 1;
    tick();
    chk("a_under_count", 32'(a_cnt), 32'h23);
    chk("a_under_bo", 32'(a_bo), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    a_dec = 0;
    chk("a_borrow_count", 32'(a_cnt), 32'h19);
    chk("a_borrow_bo", 32'(a_bo), 32'd0);

    a_load = 1; a_ld = 8'h17; tick();
    chk("a_load17", 32'(a_cnt), 32'h17);
    a_ld = 8'h24; tick();
    chk("a_load24_hold", 32'(a_cnt), 32'h17);
    chk("a_load24_err", 32'(a_le), 32'd1);
    a_ld = 8'h1A; tick();
    chk("a_load1A_err", 32'(a_le), 32'd1);
    a_ld = 8'h05; a_clr = 1; tick();
    chk("a_clr_over_load", 32'(a_cnt), 32'h00);
    a_load = 0; a_clr = 0;

    // mod 60 saturate
    b_load = 1; b_ld = 8'h59; tick();
    b_load = 0; b_inc = 1; tick();
    chk("b_sat_top", 32'(b_cnt), 32'h59);
    chk("b_sat_co", 32'(b_co), 32'd0);
    b_inc = 0; b_load = 1; b_ld = 8'h00; tick();
    b_load = 0; b_dec = 1; tick();
    chk("b_sat_bottom", 32'(b_cnt), 32'h00);
    chk("b_sat_bo", 32'(b_bo), 32'd0);
    b_dec = 0;

    // mod 1000, three digits
    c_load = 1; c_ld = 12'h999; tick();
    c_load = 0; c_inc = 1; tick();
    chk("c_wrap_count", 32'(c_cnt), 32'h000);
    chk("c_wrap_co", 32'(c_co), 32'd1);
    c_dec = 1; tick();
    chk("c_both_hold", 32'(c_cnt), 32'h000);
    chk("c_both_co", 32'(c_co), 32'd0);
    c_inc = 0; c_dec = 0;

    // chained mod60 -> mod24
    d_load = 1; d_ld = 8'h59; e_load = 1; e_ld = 8'h23; tick();
    d_load = 0; e_load = 0; d_inc = 1; tick();
    chk("d_chain_count", 32'(d_cnt), 32'h00);
    chk("d_chain_co", 32'(d_co), 32'd1);
    chk("e_chain_wait", 32'(e_cnt), 32'h23);
    d_inc = 0; tick();
    chk("e_chain_count", 32'(e_cnt), 32'h00);
    chk("e_chain_co", 32'(e_co), 32'd1);

    // asynchronous reset in the middle of a cycle with a pulse outstanding
    d_inc = 1;
    #3 rst_n = 1'b0;
    #1 clear_model();
    check_all();
    chk("e_reset_co", 32'(e_co), 32'd0);
    #2 rst_n = 1'b1;
    d_inc = 0;

    // random traffic
    for (int n = 0; n < 600; n++) begin
      a_clr = ($urandom_range(0, 24) == 0); a_load = ($urandom_range(0, 7) == 0);
      ld16 = rand_ld(30); a_ld = ld16[7:0];
      a_inc = ($urandom_range(0, 1) == 1); a_dec = ($urandom_range(0, 2) == 0);
      b_clr = ($urandom_range(0, 24) == 0); b_load = ($urandom_range(0, 7) == 0);
      ld16 = rand_ld(70); b_ld = ld16[7:0];
      b_inc = ($urandom_range(0, 1) == 1); b_dec = ($urandom_range(0, 1) == 1);
      c_clr = ($urandom_range(0, 49) == 0); c_load = ($urandom_range(0, 7) == 0);
      ld16 = rand_ld(1100); c_ld = ld16[11:0];
      c_inc = ($urandom_range(0, 1) == 1); c_dec = ($urandom_range(0, 2) == 0);
      d_clr = ($urandom_range(0, 49) == 0); d_load = ($urandom_range(0, 9) == 0);
      ld16 = rand_ld(70); d_ld = ld16[7:0];
      d_inc = ($urandom_range(0, 3) != 0); d_dec = ($urandom_range(0, 3) == 0);
      e_clr = ($urandom_range(0, 99) == 0); e_load = ($urandom_range(0, 29) == 0);
      ld16 = rand_ld(30); e_ld = ld16[7:0];
      tick();
    end

    idle_inputs();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
